// File: rtl/dl11_pkg.sv
// Shared definitions for the DL11-style serial line unit: register word
// offsets, CSR/RBUF bit positions and the transmit FSM state encoding.
package dl11_pkg;

    localparam logic [1:0] ADDR_RCSR = 2'd0;
    localparam logic [1:0] ADDR_RBUF = 2'd1;
    localparam logic [1:0] ADDR_XCSR = 2'd2;
    localparam logic [1:0] ADDR_XBUF = 2'd3;

    localparam int CSR_DONE  = 7;
    localparam int CSR_READY = 7;
    localparam int CSR_IE    = 6;
    localparam int CSR_MAINT = 2;
    localparam int RBUF_OVR  = 14;
    localparam int RBUF_ERR  = 15;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_SEND      = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/dl11_tx_ctl.sv
// Transmit sequencer: takes a byte in IDLE, pulses tx_send, then tracks the
// transmitter's busy flag with a timeout on the busy rise.
module dl11_tx_ctl
    import dl11_pkg::*;
#(
    parameter int BUSY_WAIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       tx_busy,
    output logic [7:0] tx_byte,
    output logic       tx_send,
    output tx_state_e  state
);

    localparam int CW = $clog2(BUSY_WAIT + 1);

    tx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        case (state_q)
            TX_IDLE: begin
                if (start) begin
                    byte_d  = din;
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                cnt_d   = '0;
                state_d = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                // Each cycle without busy counts toward the abort limit.
                if (tx_busy) begin
                    state_d = TX_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(BUSY_WAIT)) begin
                        state_d = TX_IDLE;
                    end
                end
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    assign tx_byte = byte_q;
    assign tx_send = (state_q == TX_SEND);
    assign state   = state_q;

endmodule

// File: rtl/serial_dl11.sv
// DL11-style serial line register window: receive buffer, CSRs, interrupts.
// Define SERIAL_DL11_MAINT_EN to enable the XCSR.MAINT loopback feature.
module serial_dl11
    import dl11_pkg::*;
#(
    parameter int BUSY_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        wr,
    input  logic        rd,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic [7:0]  rx_byte,
    input  logic        rx_ready,
    output logic        rx_read,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        irq_rx,
    output logic        irq_tx
);

    logic       rx_read_q, rx_read_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;
    logic       rie_q, rie_d;
    logic       xie_q, xie_d;
    logic       wr_rcsr, wr_xcsr, wr_xbuf, rd_rbuf;
    logic       rx_take, lb_take, tx_start, tx_ready, maint;
    tx_state_e  tx_state;
    logic       unused_din_hi;

    assign wr_rcsr  = sel & wr & (addr == ADDR_RCSR);
    assign wr_xcsr  = sel & wr & (addr == ADDR_XCSR);
    assign wr_xbuf  = sel & wr & (addr == ADDR_XBUF);
    assign rd_rbuf  = sel & rd & (addr == ADDR_RBUF);
    assign tx_ready = (tx_state == TX_IDLE);

    // A held rx_ready is acknowledged once; the cycle after an ack is skipped.
    assign rx_take = rx_ready & ~rx_read_q;
    assign rx_read = rx_take;

`ifdef SERIAL_DL11_MAINT_EN
    logic maint_q, maint_d;

    always_comb begin
        maint_d = maint_q;
        if (wr_xcsr) maint_d = din[CSR_MAINT];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) maint_q <= 1'b0;
        else        maint_q <= maint_d;
    end

    assign maint   = maint_q;
    assign lb_take = wr_xbuf & tx_ready & maint_q;
`else
    assign maint   = 1'b0;
    assign lb_take = 1'b0;
`endif

    assign tx_start = wr_xbuf & ~maint;

    always_comb begin
        rx_read_d = rx_take;
        data_d    = data_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        rie_d     = rie_q;
        xie_d     = xie_q;
        if (wr_rcsr) rie_d = din[CSR_IE];
        if (wr_xcsr) xie_d = din[CSR_IE];
        if (rd_rbuf) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end
        // An arrival in the same cycle as an RBUF read starts a fresh byte.
        if (rx_take) begin
            data_d = rx_byte;
            ovr_d  = done_q & ~rd_rbuf;
            done_d = 1'b1;
        end
        if (lb_take) begin
            data_d = din[7:0];
            ovr_d  = (done_q & ~rd_rbuf) | rx_take;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_read_q <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            rie_q     <= 1'b0;
            xie_q     <= 1'b0;
        end else begin
            rx_read_q <= rx_read_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            rie_q     <= rie_d;
            xie_q     <= xie_d;
        end
    end

    dl11_tx_ctl #(.BUSY_WAIT(BUSY_WAIT)) u_tx_ctl (
        .clk     (clk),
        .reset   (reset),
        .start   (tx_start),
        .din     (din[7:0]),
        .tx_busy (tx_busy),
        .tx_byte (tx_byte),
        .tx_send (tx_send),
        .state   (tx_state)
    );

    always_comb begin
        dout = '0;
        case (addr)
            ADDR_RCSR: begin
                dout[CSR_DONE] = done_q;
                dout[CSR_IE]   = rie_q;
            end
            ADDR_RBUF: begin
                dout[7:0]      = data_q;
                dout[RBUF_OVR] = ovr_q;
                dout[RBUF_ERR] = ovr_q;
            end
            ADDR_XCSR: begin
                dout[CSR_READY] = tx_ready;
                dout[CSR_IE]    = xie_q;
                dout[CSR_MAINT] = maint;
            end
            default: dout = '0;
        endcase
    end

    assign irq_rx = rie_q & done_q;
    assign irq_tx = xie_q & tx_ready;

    assign unused_din_hi = ^din[15:8];

endmodule
